pc_gen_unit: RTL and testbench
==============================

Name: pc_gen_unit

Overview:
- Parametrised program-counter generator for the pipelined MIPS32 core; the next generation of the synchronous PC.
- Holds a word-aligned PC of configurable width and reset vector.
- Arbitrates between exception entry, branch/jump redirect, load-use stall, halt and sequential advance.
- Adds a RUN/HALT state machine, a misaligned-target flag, a fetch-valid qualifier, and an optional return-address stack.

Parameters:
- PC_WIDTH, 12: implemented PC bits including the two zero LSBs; 3..32; upper bits of 32-bit outputs are zero.
- RESET_VEC, 32'h0000_0000: PC value after reset; bits [1:0] must be 0.
- EXC_VEC, 32'h0000_0180: exception entry address.
- RAS_DEPTH, 4: return-address stack entries; power of two, 2..16; used only with the optional feature.

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  advance enable
- load_use  in  1  hold PC (hazard stall)
- jp_success  in  1  redirect taken this cycle
- pc_new  in  32  redirect target
- exc_req  in  1  exception entry request
- halt_req  in  1  enter HALT
- resume  in  1  leave HALT
- is_call  in  1  fetched instruction is jal/jalr (RAS push)
- is_ret  in  1  fetched instruction is jr $ra (RAS pop)
- pc  out  32  current PC, zero-extended
- pc_4  out  32  pc+4 at PC_WIDTH, wraps
- fetch_valid  out  1  pc is a fetchable slot this cycle
- halted  out  1  FSM in HALT
- misalign  out  1  one-cycle pulse: last accepted redirect had pc_new[1:0] != 0
- ras_pred  out  32  RAS top-of-stack; 0 when empty or feature off
- ras_hit  out  1  is_ret && RAS non-empty

Behaviour:
- Reset (async):
  - pc = RESET_VEC truncated to PC_WIDTH; state = RUN.
  - fetch_valid = 0 in the reset cycle, then 1 from the first clock edge after reset release.
  - misalign = 0; halted = 0; RAS empty, ras_pred = 0, ras_hit = 0.
- Next-PC priority, evaluated at each rising edge, highest first:
  1. exc_req: pc <- EXC_VEC; state <- RUN.
  2. jp_success: pc <- {pc_new[PC_WIDTH-1:2], 2'b00}; misalign <- |pc_new[1:0]; state unchanged.
  3. state==RUN && halt_req: pc holds; state <- HALT.
  4. state==HALT: pc holds. resume -> RUN next edge; PC advances from the following edge.
  5. load_use: pc holds.
  6. en: pc <- pc_4.
  7. otherwise: pc holds.
- misalign is 0 on any edge where rule 2 does not apply.
- Redirect and exception take effect in HALT and override load_use, matching the existing stall/redirect policy.
- fetch_valid = (state==RUN) && !load_use, combinational from the registered state. halted = (state==HALT).
- Arithmetic: pc_4 = pc + 4 modulo 2^PC_WIDTH; all-ones word address wraps to 0.
- halt_req and resume asserted together in RUN: halt wins. In HALT: resume wins.

Optional Feature:
- Macro PC_GEN_RAS_EN.
- Defined:
  - RAS_DEPTH x PC_WIDTH circular stack with pointer and count.
  - is_call on an advancing cycle (rule 6) pushes pc_4. When full, the oldest entry is overwritten and count saturates.
  - is_ret pops when count>0. ras_hit = is_ret && count>0.
  - is_call && is_ret together: pop then push; net count unchanged, top replaced.
  - exc_req clears the stack.
  - ras_pred is combinational top-of-stack, zero-extended.
- Undefined: no storage; ras_pred = 0, ras_hit = 0; is_call and is_ret ignored.

Decomposition:
- Shared package pc_pkg holds:
  - FSM state encoding: ST_RUN=1'b0, ST_HALT=1'b1.
  - Default RESET_VEC and EXC_VEC constants.
  - MIPS word width constant 32.
- One natural sub-module, pc_ras, holding the return-address stack. It is instantiated only under PC_GEN_RAS_EN.

Test Plan:
- Reset, then en=1 for 3 cycles -> pc 0x0, 0x4, 0x8, 0xC; fetch_valid=1 after the first edge.
- jp_success=1, load_use=1, pc_new=0x0000_0106 -> pc=0x104, misalign=1 for exactly one cycle.
- PC_WIDTH=12, pc=0xFFC, en -> pc=0x000; pc_4 reads 0x000 while pc=0xFFC.
- halt_req in RUN -> halted=1, pc frozen 5 cycles with en=1; resume -> advance on the second edge; exc_req while halted -> pc=0x180, halted=0.
- exc_req and jp_success together -> pc=EXC_VEC, misalign=0.
- PC_GEN_RAS_EN, RAS_DEPTH=4: five calls at pc 0x10,0x20,0x30,0x40,0x50, then is_ret -> ras_pred=0x54, then 0x44, 0x34, 0x24, then ras_hit=0.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter generator: FSM state
// encoding, default vectors and the MIPS word width.
package pc_pkg;

  localparam int unsigned XLEN          = 32;
  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_0180;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } pc_state_e;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: circular buffer of DEPTH entries with a write
// pointer and a saturating occupancy count. When full, a push overwrites
// the oldest entry. A simultaneous pop and push replaces the top entry.
module pc_ras import pc_pkg::*; #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top,
  output logic         nonempty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] top_idx;
  logic [PW-1:0] wr_idx;
  logic          wr_en;
  logic          do_pop;

  assign top_idx  = ptr_q - PW'(1);
  assign nonempty = (cnt_q != '0);
  assign do_pop   = pop && nonempty;
  assign top      = mem_q[top_idx];

  // Next pointer/count and write slot; clear dominates, pop+push rewrites top
  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = ptr_q;
    if (clr) begin
      ptr_d = '0;
      cnt_d = '0;
    end else if (do_pop && push) begin
      wr_en  = 1'b1;
      wr_idx = top_idx;
    end else if (do_pop) begin
      ptr_d = top_idx;
      cnt_d = cnt_q - CW'(1);
    end else if (push) begin
      wr_en  = 1'b1;
      wr_idx = ptr_q;
      ptr_d  = ptr_q + PW'(1);
      cnt_d  = (cnt_q == CW'(DEPTH)) ? cnt_q : cnt_q + CW'(1);
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Stack storage; contents are only observed when the count is non-zero
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= push_data;
  end

endmodule

// File: rtl/pc_gen_unit.sv
// Program-counter generator for the pipelined MIPS32 core. Arbitrates
// exception entry, redirect, halt, load-use stall and sequential advance,
// with a RUN/HALT state machine and a misaligned-redirect pulse.
// Optional return-address stack enabled by defining PC_GEN_RAS_EN.
module pc_gen_unit import pc_pkg::*; #(
  parameter int unsigned PC_WIDTH  = 12,
  parameter logic [31:0] RESET_VEC = DEF_RESET_VEC,
  parameter logic [31:0] EXC_VEC   = DEF_EXC_VEC,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load_use,
  input  logic        jp_success,
  input  logic [31:0] pc_new,
  input  logic        exc_req,
  input  logic        halt_req,
  input  logic        resume,
  input  logic        is_call,
  input  logic        is_ret,
  output logic [31:0] pc,
  output logic [31:0] pc_4,
  output logic        fetch_valid,
  output logic        halted,
  output logic        misalign,
  output logic [31:0] ras_pred,
  output logic        ras_hit
);

  pc_state_e             state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [PC_WIDTH-1:0]   pc_inc;
  logic                  misalign_q, misalign_d;
  logic                  valid_q;
  logic                  advance;

  assign pc_inc      = pc_q + PC_WIDTH'(4);
  assign pc          = XLEN'(pc_q);
  assign pc_4        = XLEN'(pc_inc);
  assign halted      = (state_q == ST_HALT);
  assign misalign    = misalign_q;
  assign fetch_valid = valid_q && (state_q == ST_RUN) && !load_use;

  // Next-PC / next-state priority: exception, redirect, halt entry, HALT, stall, advance
  always_comb begin
    pc_d       = pc_q;
    state_d    = state_q;
    misalign_d = 1'b0;
    advance    = 1'b0;
    if (exc_req) begin
      pc_d    = PC_WIDTH'(EXC_VEC);
      state_d = ST_RUN;
    end else if (jp_success) begin
      pc_d       = {pc_new[PC_WIDTH-1:2], 2'b00};
      misalign_d = |pc_new[1:0];
    end else if (state_q == ST_RUN && halt_req) begin
      state_d = ST_HALT;
    end else if (state_q == ST_HALT) begin
      if (resume) state_d = ST_RUN;
    end else if (load_use) begin
      pc_d = pc_q;
    end else if (en) begin
      pc_d    = pc_inc;
      advance = 1'b1;
    end
  end

  // PC, FSM state, misalign pulse and post-reset fetch qualifier
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= PC_WIDTH'(RESET_VEC);
      state_q    <= ST_RUN;
      misalign_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      state_q    <= state_d;
      misalign_q <= misalign_d;
      valid_q    <= 1'b1;
    end
  end

`ifdef PC_GEN_RAS_EN
  logic [PC_WIDTH-1:0] ras_top;
  logic                ras_ne;
  logic                unused_bits;

  // Upper redirect bits above PC_WIDTH are intentionally dropped
  assign unused_bits = ^pc_new;

  pc_ras #(
    .DEPTH (RAS_DEPTH),
    .W     (PC_WIDTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (exc_req),
    .push      (is_call && advance),
    .pop       (is_ret),
    .push_data (pc_inc),
    .top       (ras_top),
    .nonempty  (ras_ne)
  );

  assign ras_pred = ras_ne ? XLEN'(ras_top) : '0;
  assign ras_hit  = is_ret && ras_ne;
`else
  logic unused_bits;

  // Call/return hints and stack depth have no effect without the stack
  assign unused_bits = ^{pc_new, is_call, is_ret, advance, RAS_DEPTH[0]};
  assign ras_pred    = '0;
  assign ras_hit     = 1'b0;
`endif

endmodule

// File: tb/tb_pc_gen_unit.sv
// Self-checking bench for pc_gen_unit: a behavioural model predicts the
// post-edge outputs for each driven cycle into a queue; entries are popped
// and compared one time unit after the rising edge.
module tb_pc_gen_unit;

  localparam int unsigned PW    = 12;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RV    = 32'h0000_0000;
  localparam logic [31:0] EV    = 32'h0000_0180;
  localparam logic [31:0] MASK  = 32'((64'd1 << PW) - 1);

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, load_use, jp_success, exc_req, halt_req, resume, is_call, is_ret;
  logic [31:0] pc_new;
  logic [31:0] pc, pc_4, ras_pred;
  logic        fetch_valid, halted, misalign, ras_hit;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] pred;
    logic        fv;
    logic        hl;
    logic        mis;
    logic        hit;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_pc;
  logic        m_halt, m_mis, m_valid;
  logic [31:0] m_ras[$];

  pc_gen_unit #(
    .PC_WIDTH  (PW),
    .RESET_VEC (RV),
    .EXC_VEC   (EV),
    .RAS_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .load_use    (load_use),
    .jp_success  (jp_success),
    .pc_new      (pc_new),
    .exc_req     (exc_req),
    .halt_req    (halt_req),
    .resume      (resume),
    .is_call     (is_call),
    .is_ret      (is_ret),
    .pc          (pc),
    .pc_4        (pc_4),
    .fetch_valid (fetch_valid),
    .halted      (halted),
    .misalign    (misalign),
    .ras_pred    (ras_pred),
    .ras_hit     (ras_hit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input logic e, input logic lu, input logic jp, input logic [31:0] pn,
                     input logic ex, input logic hr, input logic rs,
                     input logic cl, input logic rt);
    exp_t        x;
    logic        adv;
    logic [31:0] p4;
    @(negedge clk);
    en = e; load_use = lu; jp_success = jp; pc_new = pn;
    exc_req = ex; halt_req = hr; resume = rs; is_call = cl; is_ret = rt;
    adv = 1'b0;
    p4  = (m_pc + 32'd4) & MASK;
    if (ex) begin
      m_pc   = EV & MASK;
      m_halt = 1'b0;
      m_mis  = 1'b0;
      m_ras.delete();
    end else begin
      m_mis = 1'b0;
`ifdef PC_GEN_RAS_EN
      if (rt && m_ras.size() > 0) void'(m_ras.pop_back());
`endif
      if (jp) begin
        m_pc  = pn & MASK & ~32'd3;
        m_mis = |pn[1:0];
      end else if (!m_halt && hr) begin
        m_halt = 1'b1;
      end else if (m_halt) begin
        if (rs) m_halt = 1'b0;
      end else if (!lu && e) begin
        m_pc = p4;
        adv  = 1'b1;
      end
`ifdef PC_GEN_RAS_EN
      if (adv && cl) begin
        m_ras.push_back(p4);
        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
      end
`endif
    end
    m_valid = 1'b1;
    x.pc   = m_pc;
    x.pc4  = (m_pc + 32'd4) & MASK;
    x.fv   = m_valid && !m_halt && !lu;
    x.hl   = m_halt;
    x.mis  = m_mis;
    x.pred = (m_ras.size() > 0) ? m_ras[$] : 32'd0;
    x.hit  = rt && (m_ras.size() > 0);
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk("pc",          pc,                  x.pc);
    chk("pc_4",        pc_4,                x.pc4);
    chk("fetch_valid", {31'd0, fetch_valid}, {31'd0, x.fv});
    chk("halted",      {31'd0, halted},     {31'd0, x.hl});
    chk("misalign",    {31'd0, misalign},   {31'd0, x.mis});
    chk("ras_pred",    ras_pred,            x.pred);
    chk("ras_hit",     {31'd0, ras_hit},    {31'd0, x.hit});
  endtask

  // Shorthand: advance/idle cycles and redirects
  task automatic run(input logic e);
    cyc(e, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic jump(input logic [31:0] pn);
    cyc(1'b1, 1'b0, 1'b1, pn, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    en = 1'b0; load_use = 1'b0; jp_success = 1'b0; pc_new = 32'd0;
    exc_req = 1'b0; halt_req = 1'b0; resume = 1'b0; is_call = 1'b0; is_ret = 1'b0;
    m_pc = RV & MASK; m_halt = 1'b0; m_mis = 1'b0; m_valid = 1'b0;

    #12;
    chk("rst_pc",       pc,                   32'h0);
    chk("rst_fv",       {31'd0, fetch_valid}, 32'd0);
    chk("rst_halted",   {31'd0, halted},      32'd0);
    chk("rst_misalign", {31'd0, misalign},    32'd0);
    chk("rst_ras_pred", ras_pred,             32'd0);
    chk("rst_ras_hit",  {31'd0, ras_hit},     32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_fv", {31'd0, fetch_valid}, 32'd0);
    chk("rel_pc", pc,                   32'h0);

    // Sequential advance
    repeat (3) run(1'b1);

    // Redirect overrides load-use; misaligned target pulses misalign once
    cyc(1'b1, 1'b1, 1'b1, 32'h0000_0106, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("jp_pc",  pc,                32'h104);
    chk("jp_mis", {31'd0, misalign}, 32'd1);
    run(1'b0);
    chk("mis_off", {31'd0, misalign}, 32'd0);

    // Load-use stall holds pc and drops fetch_valid
    cyc(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Wrap at the top of the PC_WIDTH space
    jump(32'h0000_0FFC);
    chk("wrap_pc4", pc_4, 32'h0);
    run(1'b1);
    chk("wrap_pc", pc, 32'h0);

    // Halt entry, frozen while halted, resume then advance
    cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (5) run(1'b1);
    cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    run(1'b1);
    run(1'b1);

    // halt_req+resume in RUN: halt wins; in HALT: resume wins
    cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    // Redirect while halted, then exception leaves HALT
    cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    jump(32'h0000_0203);
    cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("exc_pc",     pc,              32'h180);
    chk("exc_halted", {31'd0, halted}, 32'd0);

    // Exception beats a simultaneous misaligned redirect
    cyc(1'b1, 1'b0, 1'b1, 32'h0000_0031, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("excjp_pc",  pc,                32'h180);
    chk("excjp_mis", {31'd0, misalign}, 32'd0);

    // Five calls at 0x10..0x50 into a four-deep stack, then five returns
    for (int i = 1; i <= 5; i++) begin
      jump(32'(i * 16));
      cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    repeat (5) cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    // Call and return together, and exception clearing the stack
    cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Randomised mix of all controls
    for (int i = 0; i < 80; i++) begin
      cyc($urandom_range(3) != 0, $urandom_range(3) == 0, $urandom_range(3) == 0,
          $urandom, $urandom_range(15) == 0, $urandom_range(7) == 0,
          $urandom_range(2) == 0, $urandom_range(2) == 0, $urandom_range(3) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
